// File: rtl/resonator_pkg.sv
// Shared types and constants for the resonator oscillator.
package resonator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_KICK = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  localparam int COEF_W_DEF     = 16;
  localparam int COEF_FRAC_W    = COEF_W_DEF - 2;
  localparam int COEF_RESET_DEF = 16384;

  // Coefficients are Q2.x: two integer bits including sign.
  function automatic int q_frac_w(input int coef_w);
    return coef_w - 2;
  endfunction

endpackage

// File: rtl/resonator_if.sv
// Control, coefficient handshake and sample output bundle of the resonator.
interface resonator_if #(
  parameter int DATA_W = 8,
  parameter int COEF_W = 16
);
  logic                     sample_en;
  logic                     start;
  logic                     stop;
  logic signed [DATA_W-1:0] amp;
  logic signed [COEF_W-1:0] coef_in;
  logic                     coef_valid;
  logic                     coef_ready;
  logic signed [DATA_W-1:0] out;
  logic                     out_valid;
  logic                     sat;

  modport master (
    output sample_en, start, stop, amp, coef_in, coef_valid,
    input  coef_ready, out, out_valid, sat
  );

  modport slave (
    input  sample_en, start, stop, amp, coef_in, coef_valid,
    output coef_ready, out, out_valid, sat
  );
endinterface

// File: rtl/sat_trunc.sv
// Signed saturating narrower: clamps IN_W to OUT_W range and flags any clip.
module sat_trunc #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 8
) (
  input  logic signed [IN_W-1:0]  in_i,
  output logic signed [OUT_W-1:0] out_o,
  output logic                    clip_o
);
  logic [IN_W-OUT_W:0] top_s;

  // Value fits when all bits above the target sign bit equal the sign.
  always_comb begin
    top_s = in_i[IN_W-1:OUT_W-1];
    if ((&top_s) || !(|top_s)) begin
      out_o  = in_i[OUT_W-1:0];
      clip_o = 1'b0;
    end else begin
      out_o  = in_i[IN_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
      clip_o = 1'b1;
    end
  end
endmodule

// File: rtl/resonator_osc.sv
// Impulse-kicked second-order resonator: y = 2cos(w)*y1 - y2, with a
// handshaked coefficient update applied on the next sample.
module resonator_osc
  import resonator_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int GUARD_W    = 4,
  parameter int COEF_W     = COEF_W_DEF,
  parameter int COEF_RESET = COEF_RESET_DEF
) (
  input logic        clk,
  input logic        reset,
  resonator_if.slave bus
);
  localparam int STATE_W = DATA_W + GUARD_W;
  localparam int PROD_W  = COEF_W + STATE_W;
  localparam int SUM_W   = PROD_W + 1;
  localparam int FRAC_W  = q_frac_w(COEF_W);

  state_e                    state_q, state_d;
  logic signed [STATE_W-1:0] y1_q, y1_d, y2_q, y2_d, y_state_s;
  logic signed [DATA_W-1:0]  amp_q, amp_d, out_q, out_d, y_out_s;
  logic signed [COEF_W-1:0]  coef_q, coef_d, pend_q, pend_d, coef_use_s;
  logic                      pend_v_q, pend_v_d, out_valid_q, out_valid_d, sat_q, sat_d;
  logic                      clip_state_s, clip_out_s;
  logic signed [PROD_W-1:0]  coef_ext_s, y1_ext_s, prod_s, shift_s;
  logic signed [SUM_W-1:0]   y_calc_s, y_raw_s;

  // A pending coefficient takes effect on the sample that retires it.
  assign coef_use_s = pend_v_q ? pend_q : coef_q;
  assign coef_ext_s = {{STATE_W{coef_use_s[COEF_W-1]}}, coef_use_s};
  assign y1_ext_s   = {{COEF_W{y1_q[STATE_W-1]}}, y1_q};
  assign prod_s     = coef_ext_s * y1_ext_s;
  assign shift_s    = prod_s >>> FRAC_W;
  assign y_calc_s   = {shift_s[PROD_W-1], shift_s} - {{(SUM_W-STATE_W){y2_q[STATE_W-1]}}, y2_q};
  assign y_raw_s    = (state_q == ST_KICK) ? {{(SUM_W-DATA_W){amp_q[DATA_W-1]}}, amp_q} : y_calc_s;

  sat_trunc #(.IN_W(SUM_W), .OUT_W(STATE_W)) u_sat_state (
    .in_i(y_raw_s), .out_o(y_state_s), .clip_o(clip_state_s)
  );

  sat_trunc #(.IN_W(STATE_W), .OUT_W(DATA_W)) u_sat_out (
    .in_i(y_state_s), .out_o(y_out_s), .clip_o(clip_out_s)
  );

  // Next-state: FSM, recursion update, coefficient handshake.
  always_comb begin
    state_d     = state_q;
    y1_d        = y1_q;
    y2_d        = y2_q;
    amp_d       = amp_q;
    out_d       = out_q;
    out_valid_d = 1'b0;
    sat_d       = sat_q;
    coef_d      = coef_q;
    pend_d      = pend_q;
    pend_v_d    = pend_v_q;

    if (bus.coef_valid && !pend_v_q) begin
      pend_d   = bus.coef_in;
      pend_v_d = 1'b1;
    end else if (bus.sample_en && pend_v_q) begin
      coef_d   = pend_q;
      pend_v_d = 1'b0;
    end else begin
      pend_v_d = pend_v_q;
    end

    case (state_q)
      ST_IDLE: begin
        out_d = '0;
        if (bus.start && !bus.stop) begin
          state_d = ST_KICK;
          amp_d   = bus.amp;
          sat_d   = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_KICK, ST_RUN: begin
        if (bus.stop) begin
          state_d = ST_IDLE;
          y1_d    = '0;
          y2_d    = '0;
          out_d   = '0;
        end else if (bus.sample_en) begin
          state_d     = ST_RUN;
          y1_d        = y_state_s;
          y2_d        = y1_q;
          out_d       = y_out_s;
          out_valid_d = 1'b1;
          sat_d       = sat_q | clip_state_s | clip_out_s;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        y1_d    = '0;
        y2_d    = '0;
        out_d   = '0;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      y1_q        <= '0;
      y2_q        <= '0;
      amp_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      sat_q       <= 1'b0;
      coef_q      <= COEF_W'(COEF_RESET);
      pend_q      <= '0;
      pend_v_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      y1_q        <= y1_d;
      y2_q        <= y2_d;
      amp_q       <= amp_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      sat_q       <= sat_d;
      coef_q      <= coef_d;
      pend_q      <= pend_d;
      pend_v_q    <= pend_v_d;
    end
  end

  assign bus.coef_ready = !pend_v_q;
  assign bus.out        = out_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.sat        = sat_q;
endmodule
